// File: rtl/id_stage_if.sv
// id_stage_if: bundles the fetch-side inputs, execute/write-back side-band
// inputs and the decoded bundle leaving the decode stage.
//   slave  : view used by id_stage (consumes IF_*, Flush, EX_*, WB_*;
//            drives Stall and the ID bundle)
//   master : view used by the surrounding pipeline / testbench
interface id_stage_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic [DATA_W-1:0] IF_PC, IF_nextPC, IF_Ins;
  logic              Flush;
  logic              EX_MemRead;
  logic [AW-1:0]     EX_Rt;
  logic              WB_WE;
  logic [AW-1:0]     WB_Addr;
  logic [DATA_W-1:0] WB_Data;

  logic              Stall, ID_Valid;
  logic [DATA_W-1:0] ID_PC, ID_nextPC;
  logic [5:0]        Op, Funct;
  logic [AW-1:0]     Rs, Rt, Rd, Shamt;
  logic [DATA_W-1:0] RD1, RD2, ImmExt, BrTarget, JTarget;

  modport slave (
    input  IF_PC, IF_nextPC, IF_Ins, Flush, EX_MemRead, EX_Rt,
           WB_WE, WB_Addr, WB_Data,
    output Stall, ID_Valid, ID_PC, ID_nextPC, Op, Funct, Rs, Rt, Rd, Shamt,
           RD1, RD2, ImmExt, BrTarget, JTarget
  );

  modport master (
    output IF_PC, IF_nextPC, IF_Ins, Flush, EX_MemRead, EX_Rt,
           WB_WE, WB_Addr, WB_Data,
    input  Stall, ID_Valid, ID_PC, ID_nextPC, Op, Funct, Rs, Rt, Rd, Shamt,
           RD1, RD2, ImmExt, BrTarget, JTarget
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage.
//   IF/ID pipeline register, 32-entry register file with write-through
//   bypass, field/immediate decode, branch/jump target generation and
//   load-use hazard detection.
// Ports:
//   CLK  clock, all state on posedge
//   RST  synchronous active-high reset
//   bus  id_stage_if.slave: fetch inputs, Flush, EX load info, WB write
//        port in; Stall plus the valid-tagged decoded bundle out.
module id_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input logic         CLK,
  input logic         RST,
  id_stage_if.slave   bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] ins_q, pc_q, nextpc_q;
  logic              v_q;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic [AW-1:0]     rs, rt;
  logic [5:0]        op;
  logic [DATA_W-1:0] imm_sx;
  logic              uses_rt, hazard, stall;

  assign op = ins_q[31:26];
  assign rs = ins_q[25:21];
  assign rt = ins_q[20:16];

  // IF/ID register: Flush beats Stall, so a killed instruction never lingers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ins_q    <= '0;
      pc_q     <= '0;
      nextpc_q <= '0;
      v_q      <= 1'b0;
    end else if (bus.Flush) begin
      ins_q <= '0;
      v_q   <= 1'b0;
    end else if (!stall) begin
      ins_q    <= bus.IF_Ins;
      pc_q     <= bus.IF_PC;
      nextpc_q <= bus.IF_nextPC;
      v_q      <= 1'b1;
    end
  end

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (bus.WB_WE && bus.WB_Addr != '0) begin
      rf[bus.WB_Addr] <= bus.WB_Data;
    end
  end

  // Write-through bypass so a write landing this edge is seen by decode now.
  always_comb begin
    bus.RD1 = rf[rs];
    bus.RD2 = rf[rt];
    if (bus.WB_WE && bus.WB_Addr != '0 && bus.WB_Addr == rs) bus.RD1 = bus.WB_Data;
    if (bus.WB_WE && bus.WB_Addr != '0 && bus.WB_Addr == rt) bus.RD2 = bus.WB_Data;
    if (rs == '0) bus.RD1 = '0;
    if (rt == '0) bus.RD2 = '0;
  end

  // Only R-type, beq, bne and sw actually read Rt; other formats write it.
  assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  assign hazard  = v_q && bus.EX_MemRead && bus.EX_Rt != '0 &&
                   (bus.EX_Rt == rs || (uses_rt && bus.EX_Rt == rt));
  assign stall   = hazard && !bus.Flush && !RST;

  assign bus.Stall    = stall;
  assign bus.ID_Valid = v_q && !stall && !bus.Flush;
  assign bus.ID_PC     = pc_q;
  assign bus.ID_nextPC = nextpc_q;
  assign bus.Op    = op;
  assign bus.Funct = ins_q[5:0];
  assign bus.Rs    = rs;
  assign bus.Rt    = rt;
  assign bus.Rd    = ins_q[15:11];
  assign bus.Shamt = ins_q[10:6];

  // Logical immediates are zero-extended; branches always use the signed form.
  assign imm_sx       = {{(DATA_W-16){ins_q[15]}}, ins_q[15:0]};
  assign bus.ImmExt   = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ?
                        {{(DATA_W-16){1'b0}}, ins_q[15:0]} : imm_sx;
  assign bus.BrTarget = nextpc_q + {imm_sx[DATA_W-3:0], 2'b00};
  assign bus.JTarget  = {nextpc_q[31:28], ins_q[25:0], 2'b00};
endmodule
